window_actuator_responder: RTL and testbench
============================================

Name: window_actuator_responder

Overview:
- Responder end of the window-open command interface.
- Accepts window-open requests (t_wo strobe plus id_wo) and close-all requests (clr) from the window-open driver.
- Serializes them onto one shared window motor: one window moves at a time, each move is timed by a travel counter, and moves are separated by a settle gap.
- Reports per-window open state and busy/done/err status back to the driver and the LED logic.

Parameters:
- N_WIN, 6, number of windows; valid ids are 0..N_WIN-1 (max 8).
- TRAVEL_CYC, 20, clock cycles the motor runs per move (>=1).
- GAP_CYC, 2, idle cycles after a move before the next one starts (>=0).
- CW, 8, counter width; must hold max(TRAVEL_CYC, GAP_CYC).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (rst=0 resets).
- t_wo  in  1  single-cycle open request for window id_wo.
- id_wo  in  3  window index sampled when t_wo=1.
- clr  in  1  single-cycle close-all request.
- motor_en  out  1  motor running.
- motor_dir  out  1  1=opening, 0=closing; valid while motor_en=1.
- motor_sel  out  3  window being driven; valid while motor_en=1.
- win_open  out  N_WIN  1 = window fully open.
- busy  out  1  motor moving, settling, or any request pending.
- done  out  1  one-cycle pulse when a move completes.
- err  out  1  one-cycle pulse on a t_wo with id_wo >= N_WIN.

Behaviour:
- Reset values: all outputs 0, every window CLOSED, pending masks cleared, FSM in IDLE, counters 0.
- Per-window registers:
  - pend_open[N_WIN] and pend_close[N_WIN].
  - Window state CLOSED, MOVING or OPEN.
- t_wo, valid id:
  - Sets pend_open[id] only if the window is CLOSED, or MOVING with dir=0 (closing).
  - Otherwise ignored: no pending bit, no err.
- t_wo, invalid id (id_wo >= N_WIN): err=1 on the next cycle, no other effect.
- clr:
  - For every window OPEN, or MOVING with dir=1: sets pend_close.
  - Clears all pend_open bits.
- clr and t_wo in the same cycle: clr wins, the t_wo is dropped, no err even if the id is invalid.
- FSM IDLE:
  - If any pending bit is set, select the lowest index i with pend_open[i] or pend_close[i].
  - If both bits are set for i, pend_close wins and pend_open stays pending.
  - Clear the chosen bit, load the travel counter, go to MOVE.
  - Latency: request in cycle N, IDLE sees it in N+1, motor_en=1 from N+2.
- FSM MOVE:
  - motor_en=1 with motor_sel=i and motor_dir fixed for the whole move; window state MOVING.
  - Counter decrements each cycle, so motor_en is high exactly TRAVEL_CYC cycles.
  - On the last cycle: set window state to OPEN or CLOSED, update win_open, pulse done the following cycle.
  - Go to GAP, or straight to IDLE when GAP_CYC=0.
- FSM GAP: motor_en=0 for GAP_CYC cycles, then IDLE.
- Requests arriving during MOVE or GAP only update the pending masks. The current move is never aborted.
- A close request for the window currently moving open is served after the open completes, so the window reopens then closes.
- A duplicate t_wo for an already-pending window has no additional effect (the pending bit is idempotent).
- busy = (FSM != IDLE) OR any pending bit set. busy is registered.
- Reset asserted mid-move: motor_en drops immediately (async), all windows return to CLOSED state, and pending requests are lost.
- All counters saturate at 0 and never wrap.

Decomposition:
- Shared package (thermostat_pkg): FSM state encoding (IDLE, MOVE, GAP), window state encoding (CLOSED, MOVING, OPEN), DIR_OPEN=1 and DIR_CLOSE=0 constants.
- Sub-module: window_pend_arbiter. It is a combinational lowest-index priority pick over pend_open | pend_close and returns the index, the direction and a valid flag.
- The FSM, counters and per-window registers stay in the top module.

Test Plan:
- Single open: TRAVEL_CYC=20, GAP_CYC=2, pulse t_wo with id_wo=3. Required: motor_en=1 with sel=3 and dir=1 for exactly 20 cycles, starting 2 cycles after t_wo; done pulses once; win_open=6'b001000; busy falls 2 cycles after the move ends.
- Queueing: t_wo id=4, then t_wo id=1 and t_wo id=2 while id 4 is moving. Required: move order 4, 1, 2; win_open=6'b010110 at the end.
- Invalid id and duplicate: t_wo id=7 gives err for 1 cycle and no motor activity. Two t_wo id=0 pulses 3 cycles apart give exactly one move.
- clr during opening: t_wo id=2, then clr at cycle 10 of the move. Required: the open completes, GAP follows, then a close of window 2 with dir=0; final win_open=0.
- Simultaneous clr and t_wo: windows 0 and 5 open, then clr and t_wo id=1 in the same cycle. Required: closes of 0 then 5 only; window 1 never moves; no err.
- Reset mid-move: drop rst at cycle 5 of an open of window 2. Required: all outputs 0 immediately; after release, no motor activity and win_open=0.

Source files
------------

// File: rtl/thermostat_pkg.sv
// rtl/thermostat_pkg.sv - shared encodings for the window actuator responder
//
// Contents:
//   IDW          width of a window index (up to 8 windows)
//   fsm_state_t  motor sequencer states: IDLE, MOVE, GAP
//   win_state_t  per-window position: CLOSED, MOVING, OPEN
//   DIR_OPEN / DIR_CLOSE  motor direction values
package thermostat_pkg;

    localparam int IDW = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MOVE = 2'd1,
        ST_GAP  = 2'd2
    } fsm_state_t;

    typedef enum logic [1:0] {
        WIN_CLOSED = 2'd0,
        WIN_MOVING = 2'd1,
        WIN_OPEN   = 2'd2
    } win_state_t;

    localparam logic DIR_OPEN  = 1'b1;
    localparam logic DIR_CLOSE = 1'b0;

endpackage

// File: rtl/window_actuator_responder_if.sv
// rtl/window_actuator_responder_if.sv - window-open command interface between driver and responder
//
// Signals:
//   t_wo, id_wo, clr            requests from the driver
//   motor_en, motor_dir, motor_sel  shared motor drive
//   win_open[N_WIN]             per-window fully-open flags
//   busy, done, err             status back to driver / LED logic
// Modports: master (driver side), slave (responder side).
interface window_actuator_responder_if #(
    parameter int N_WIN = 6
);
    logic                          t_wo;
    logic [thermostat_pkg::IDW-1:0] id_wo;
    logic                          clr;
    logic                          motor_en;
    logic                          motor_dir;
    logic [thermostat_pkg::IDW-1:0] motor_sel;
    logic [N_WIN-1:0]              win_open;
    logic                          busy;
    logic                          done;
    logic                          err;

    modport master (
        output t_wo, id_wo, clr,
        input  motor_en, motor_dir, motor_sel, win_open, busy, done, err
    );

    modport slave (
        input  t_wo, id_wo, clr,
        output motor_en, motor_dir, motor_sel, win_open, busy, done, err
    );
endinterface

// File: rtl/window_pend_arbiter.sv
// rtl/window_pend_arbiter.sv - lowest-index pick over pending open/close requests
//
// Ports:
//   pend_open, pend_close  in   per-window pending masks
//   pick_idx               out  lowest index with any pending bit
//   pick_dir               out  DIR_CLOSE if a close is pending there, else DIR_OPEN
//   pick_valid             out  any pending bit set
module window_pend_arbiter
    import thermostat_pkg::*;
#(
    parameter int N_WIN = 6
) (
    input  logic [N_WIN-1:0] pend_open,
    input  logic [N_WIN-1:0] pend_close,
    output logic [IDW-1:0]   pick_idx,
    output logic             pick_dir,
    output logic             pick_valid
);

    always_comb begin
        pick_idx   = '0;
        pick_dir   = DIR_OPEN;
        pick_valid = 1'b0;
        // Scan downwards so the last hit, i.e. the lowest index, wins.
        for (int i = N_WIN - 1; i >= 0; i--) begin
            if (pend_open[i] || pend_close[i]) begin
                pick_idx   = IDW'(i);
                // A close outranks an open on the same window; the open stays queued.
                pick_dir   = pend_close[i] ? DIR_CLOSE : DIR_OPEN;
                pick_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/window_actuator_responder.sv
// rtl/window_actuator_responder.sv - serializes window open/close requests onto one shared motor
//
// Ports:
//   clk  in   system clock, rising edge
//   rst  in   asynchronous active-low reset
//   bus  slave modport of window_actuator_responder_if (requests in, motor/status out)
// Parameters: N_WIN windows, TRAVEL_CYC motor cycles per move, GAP_CYC settle cycles,
//   CW counter width.
module window_actuator_responder
    import thermostat_pkg::*;
#(
    parameter int N_WIN      = 6,
    parameter int TRAVEL_CYC = 20,
    parameter int GAP_CYC    = 2,
    parameter int CW         = 8
) (
    input logic                          clk,
    input logic                          rst,
    window_actuator_responder_if.slave   bus
);

    localparam logic [IDW:0] N_WIN_W = (IDW + 1)'(N_WIN);

    fsm_state_t       state_q, state_nxt;
    logic [CW-1:0]    cnt_q, cnt_nxt;
    logic [IDW-1:0]   sel_q, sel_nxt;
    logic             dir_q, dir_nxt;
    logic [N_WIN-1:0] pend_open_q, pend_open_nxt;
    logic [N_WIN-1:0] pend_close_q, pend_close_nxt;
    win_state_t       win_state_q   [N_WIN];
    win_state_t       win_state_nxt [N_WIN];
    logic             busy_q, busy_nxt;
    logic             done_q, done_nxt;
    logic             err_q, err_nxt;

    logic             pick_valid;
    logic [IDW-1:0]   pick_idx;
    logic             pick_dir;
    logic             launch;
    logic             last_travel;
    logic             id_ok;
    logic             launch_here;
    logic             eff_moving_open;
    logic             eff_moving_close;

    window_pend_arbiter #(
        .N_WIN (N_WIN)
    ) u_arb (
        .pend_open  (pend_open_q),
        .pend_close (pend_close_q),
        .pick_idx   (pick_idx),
        .pick_dir   (pick_dir),
        .pick_valid (pick_valid)
    );

    assign id_ok       = {1'b0, bus.id_wo} < N_WIN_W;
    assign last_travel = (state_q == ST_MOVE) && (cnt_q <= CW'(1));

    always_comb begin
        state_nxt        = state_q;
        cnt_nxt          = cnt_q;
        sel_nxt          = sel_q;
        dir_nxt          = dir_q;
        pend_open_nxt    = pend_open_q;
        pend_close_nxt   = pend_close_q;
        win_state_nxt    = win_state_q;
        done_nxt         = 1'b0;
        err_nxt          = 1'b0;
        launch           = 1'b0;
        launch_here      = 1'b0;
        eff_moving_open  = 1'b0;
        eff_moving_close = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    launch    = 1'b1;
                    sel_nxt   = pick_idx;
                    dir_nxt   = pick_dir;
                    cnt_nxt   = CW'(TRAVEL_CYC);
                    state_nxt = ST_MOVE;
                end
            end
            ST_MOVE: begin
                if (last_travel) begin
                    done_nxt = 1'b1;
                    if (GAP_CYC == 0) begin
                        state_nxt = ST_IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = ST_GAP;
                        cnt_nxt   = CW'(GAP_CYC);
                    end
                end else if (cnt_q != '0) begin
                    cnt_nxt = cnt_q - CW'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q <= CW'(1)) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_q - CW'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase

        for (int i = 0; i < N_WIN; i++) begin
            launch_here = launch && (pick_idx == IDW'(i));

            // Consume the request being launched before new requests are merged,
            // so a request arriving in the launch cycle is judged against the
            // move that is starting rather than the stale CLOSED/OPEN state.
            if (launch_here) begin
                if (pick_dir == DIR_CLOSE) begin
                    pend_close_nxt[i] = 1'b0;
                end else begin
                    pend_open_nxt[i] = 1'b0;
                end
                win_state_nxt[i] = WIN_MOVING;
            end

            if (last_travel && (sel_q == IDW'(i))) begin
                win_state_nxt[i] = (dir_q == DIR_OPEN) ? WIN_OPEN : WIN_CLOSED;
            end

            eff_moving_open  = ((win_state_q[i] == WIN_MOVING) && (dir_q == DIR_OPEN))
                             || (launch_here && (pick_dir == DIR_OPEN));
            eff_moving_close = ((win_state_q[i] == WIN_MOVING) && (dir_q == DIR_CLOSE))
                             || (launch_here && (pick_dir == DIR_CLOSE));

            if (bus.clr) begin
                if ((win_state_q[i] == WIN_OPEN && !launch_here) || eff_moving_open) begin
                    pend_close_nxt[i] = 1'b1;
                end
                pend_open_nxt[i] = 1'b0;
            end else if (bus.t_wo && id_ok && (bus.id_wo == IDW'(i))) begin
                if ((win_state_q[i] == WIN_CLOSED && !launch_here) || eff_moving_close) begin
                    pend_open_nxt[i] = 1'b1;
                end
            end
        end

        // clr swallows a simultaneous t_wo, including its error report.
        err_nxt  = bus.t_wo && !bus.clr && !id_ok;
        busy_nxt = (state_nxt != ST_IDLE) || (|pend_open_nxt) || (|pend_close_nxt);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            sel_q        <= '0;
            dir_q        <= DIR_CLOSE;
            pend_open_q  <= '0;
            pend_close_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            for (int i = 0; i < N_WIN; i++) begin
                win_state_q[i] <= WIN_CLOSED;
            end
        end else begin
            state_q      <= state_nxt;
            cnt_q        <= cnt_nxt;
            sel_q        <= sel_nxt;
            dir_q        <= dir_nxt;
            pend_open_q  <= pend_open_nxt;
            pend_close_q <= pend_close_nxt;
            busy_q       <= busy_nxt;
            done_q       <= done_nxt;
            err_q        <= err_nxt;
            for (int i = 0; i < N_WIN; i++) begin
                win_state_q[i] <= win_state_nxt[i];
            end
        end
    end

    // Motor outputs come straight from registers so an async reset stops the motor at once.
    assign bus.motor_en  = (state_q == ST_MOVE);
    assign bus.motor_sel = bus.motor_en ? sel_q : '0;
    assign bus.motor_dir = bus.motor_en ? dir_q : DIR_CLOSE;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;

    always_comb begin
        bus.win_open = '0;
        for (int i = 0; i < N_WIN; i++) begin
            bus.win_open[i] = (win_state_q[i] == WIN_OPEN);
        end
    end

endmodule

// File: tb/tb_window_actuator_responder.sv
// tb/tb_window_actuator_responder.sv - directed self-checking bench for window_actuator_responder
module tb_window_actuator_responder;

    localparam int N_WIN      = 6;
    localparam int TRAVEL_CYC = 20;
    localparam int GAP_CYC    = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;

    int compared   = 0;
    int mismatched = 0;

    window_actuator_responder_if #(.N_WIN(N_WIN)) bus ();

    window_actuator_responder #(
        .N_WIN      (N_WIN),
        .TRAVEL_CYC (TRAVEL_CYC),
        .GAP_CYC    (GAP_CYC),
        .CW         (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Move recorder: one entry per contiguous motor_en burst.
    int mv_n = 0;
    int mv_sel   [64];
    int mv_dir   [64];
    int mv_len   [64];
    int mv_start [64];
    int mv_last  [64];
    int unstable = 0;
    int done_n = 0;
    int done_cyc = 0;
    int err_n = 0;
    int busy_fall_cyc = 0;
    logic in_move = 1'b0;
    logic prev_busy = 1'b0;
    int cur_sel, cur_dir, cur_len, cur_start, cur_last;

    always @(negedge clk) begin
        if (bus.motor_en) begin
            if (!in_move) begin
                in_move   = 1'b1;
                cur_sel   = int'(bus.motor_sel);
                cur_dir   = int'(bus.motor_dir);
                cur_len   = 1;
                cur_start = cyc;
            end else begin
                cur_len++;
                if (int'(bus.motor_sel) != cur_sel || int'(bus.motor_dir) != cur_dir) unstable++;
            end
            cur_last = cyc;
        end else if (in_move) begin
            in_move = 1'b0;
            if (mv_n < 64) begin
                mv_sel[mv_n]   = cur_sel;
                mv_dir[mv_n]   = cur_dir;
                mv_len[mv_n]   = cur_len;
                mv_start[mv_n] = cur_start;
                mv_last[mv_n]  = cur_last;
                mv_n++;
            end
        end
        if (bus.done) begin
            done_n++;
            done_cyc = cyc;
        end
        if (bus.err) err_n++;
        if (prev_busy && !bus.busy) busy_fall_cyc = cyc;
        prev_busy = bus.busy;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_wo(input logic [2:0] id);
        bus.t_wo  = 1'b1;
        bus.id_wo = id;
        tick();
        bus.t_wo  = 1'b0;
        bus.id_wo = 3'd0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((bus.busy || bus.motor_en || in_move) && n < 400) begin
            tick();
            n++;
        end
        check({tag, "_idle_timeout"}, 32'(n < 400), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    int base, d0, e0, rc;

    initial begin
        bus.t_wo  = 1'b0;
        bus.id_wo = 3'd0;
        bus.clr   = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_motor_en", 32'(bus.motor_en), 32'd0);
        check("rst_win_open", 32'(bus.win_open), 32'd0);
        check("rst_busy",     32'(bus.busy),     32'd0);
        check("rst_done",     32'(bus.done),     32'd0);
        check("rst_err",      32'(bus.err),      32'd0);
        rst = 1'b1;
        tick();
        tick();

        // Single open of window 3
        base = mv_n;
        d0   = done_n;
        rc   = cyc;
        pulse_wo(3'd3);
        check("t1_busy_early",   32'(bus.busy),     32'd1);
        check("t1_motor_early",  32'(bus.motor_en), 32'd0);
        wait_idle("t1");
        check("t1_moves",     32'(mv_n - base),      32'd1);
        check("t1_sel",       32'(mv_sel[base]),     32'd3);
        check("t1_dir",       32'(mv_dir[base]),     32'd1);
        check("t1_len",       32'(mv_len[base]),     32'd20);
        check("t1_start",     32'(mv_start[base]),   32'(rc + 2));
        check("t1_done_n",    32'(done_n - d0),      32'd1);
        check("t1_done_cyc",  32'(done_cyc),         32'(mv_last[base] + 1));
        check("t1_busy_fall", 32'(busy_fall_cyc),    32'(mv_last[base] + 3));
        check("t1_win_open",  32'(bus.win_open),     32'b001000);

        // Queueing: 4 moving, then 1 and 2 requested
        do_reset();
        base = mv_n;
        pulse_wo(3'd4);
        tick(); tick(); tick(); tick();
        pulse_wo(3'd1);
        pulse_wo(3'd2);
        wait_idle("t2");
        check("t2_moves",    32'(mv_n - base),      32'd3);
        check("t2_sel0",     32'(mv_sel[base]),     32'd4);
        check("t2_sel1",     32'(mv_sel[base + 1]), 32'd1);
        check("t2_sel2",     32'(mv_sel[base + 2]), 32'd2);
        check("t2_len2",     32'(mv_len[base + 2]), 32'd20);
        check("t2_gap",      32'(mv_start[base + 1]), 32'(mv_last[base] + 4));
        check("t2_win_open", 32'(bus.win_open),     32'b010110);

        // Invalid id, then duplicate request
        do_reset();
        base = mv_n;
        e0   = err_n;
        pulse_wo(3'd7);
        check("t3_err_hi", 32'(bus.err), 32'd1);
        tick();
        check("t3_err_lo", 32'(bus.err), 32'd0);
        tick(); tick(); tick();
        check("t3_no_move", 32'(mv_n - base),  32'd0);
        check("t3_busy",    32'(bus.busy),     32'd0);
        check("t3_err_n",   32'(err_n - e0),   32'd1);
        pulse_wo(3'd0);
        tick(); tick();
        pulse_wo(3'd0);
        wait_idle("t3");
        check("t3_dup_moves", 32'(mv_n - base),  32'd1);
        check("t3_dup_sel",   32'(mv_sel[base]), 32'd0);
        check("t3_win_open",  32'(bus.win_open), 32'b000001);

        // clr at cycle 10 of an opening move
        do_reset();
        base = mv_n;
        rc   = cyc;
        pulse_wo(3'd2);
        while (cyc < rc + 11) tick();
        check("t4_moving", 32'(bus.motor_en), 32'd1);
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        wait_idle("t4");
        check("t4_moves",    32'(mv_n - base),        32'd2);
        check("t4_len0",     32'(mv_len[base]),       32'd20);
        check("t4_dir0",     32'(mv_dir[base]),       32'd1);
        check("t4_sel1",     32'(mv_sel[base + 1]),   32'd2);
        check("t4_dir1",     32'(mv_dir[base + 1]),   32'd0);
        check("t4_gap",      32'(mv_start[base + 1]), 32'(mv_last[base] + 4));
        check("t4_win_open", 32'(bus.win_open),       32'd0);

        // clr with simultaneous t_wo (valid and invalid)
        do_reset();
        pulse_wo(3'd0);
        pulse_wo(3'd5);
        wait_idle("t5a");
        check("t5_open_pre", 32'(bus.win_open), 32'b100001);
        base = mv_n;
        e0   = err_n;
        bus.clr   = 1'b1;
        bus.t_wo  = 1'b1;
        bus.id_wo = 3'd1;
        tick();
        bus.id_wo = 3'd7;
        tick();
        bus.clr  = 1'b0;
        bus.t_wo = 1'b0;
        bus.id_wo = 3'd0;
        wait_idle("t5b");
        check("t5_moves",    32'(mv_n - base),      32'd2);
        check("t5_sel0",     32'(mv_sel[base]),     32'd0);
        check("t5_dir0",     32'(mv_dir[base]),     32'd0);
        check("t5_sel1",     32'(mv_sel[base + 1]), 32'd5);
        check("t5_dir1",     32'(mv_dir[base + 1]), 32'd0);
        check("t5_no_err",   32'(err_n - e0),       32'd0);
        check("t5_win_open", 32'(bus.win_open),     32'd0);

        // Reset asserted at cycle 5 of an open of window 2
        do_reset();
        base = mv_n;
        rc   = cyc;
        pulse_wo(3'd2);
        while (cyc < rc + 6) tick();
        check("t6_moving", 32'(bus.motor_en), 32'd1);
        rst = 1'b0;
        #1;
        check("t6_motor_en", 32'(bus.motor_en), 32'd0);
        check("t6_busy",     32'(bus.busy),     32'd0);
        check("t6_sel",      32'(bus.motor_sel), 32'd0);
        check("t6_win_open", 32'(bus.win_open), 32'd0);
        tick(); tick();
        rst = 1'b1;
        for (int i = 0; i < 30; i++) tick();
        check("t6_moves",     32'(mv_n - base),  32'd1);
        check("t6_len",       32'(mv_len[base]), 32'd5);
        check("t6_busy_post", 32'(bus.busy),     32'd0);
        check("t6_open_post", 32'(bus.win_open), 32'd0);
        check("t6_unstable",  32'(unstable),     32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
